pipelined_subtractor_32bits: RTL



---
 rtl/pipelined_subtractor_32bits.sv | 121 ++++++++++++
 1 files changed

// File: rtl/pipelined_subtractor_32bits.sv
// pipelined_subtractor_32bits
//
// Two-stage pipelined 32-bit unsigned subtractor for the LZ77 match stage.
// It computes match distance = current position - candidate position (- borrow-in)
// and flags whether that distance is a legal Deflate back-reference.
// Stage 1 subtracts the low 16 bits. Stage 2 subtracts the high 16 bits,
// performs the window check and holds the result until the consumer takes it.
//
// Ports
//   clk            single clock, rising edge
//   rst_n          asynchronous, active-low reset
//   in_valid       operand pair present
//   in_ready       block can accept an operand pair this cycle
//   in_a           minuend (current position)
//   in_b           subtrahend (candidate position)
//   in_bi          borrow-in; subtracts an extra 1 when high
//   in_tag         sideband tag, returned unchanged with the result
//   out_valid      result present
//   out_ready      consumer accepts the result this cycle
//   out_diff       (in_a - in_b - in_bi) mod 2^32
//   out_bo         borrow-out, high iff in_a < in_b + in_bi
//   out_in_window  high iff no borrow and 1 <= out_diff <= 2^WINDOW_BITS
//   out_tag        tag of this result
module pipelined_subtractor_32bits #(
    parameter int WINDOW_BITS = 15,
    parameter int TAG_WIDTH   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_a,
    input  logic [31:0]          in_b,
    input  logic                 in_bi,
    input  logic [TAG_WIDTH-1:0] in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_diff,
    output logic                 out_bo,
    output logic                 out_in_window,
    output logic [TAG_WIDTH-1:0] out_tag
);

    // Largest legal distance, held at 33 bits so WINDOW_BITS up to 32 still fits.
    localparam logic [32:0] WINDOW_MAX = 33'(1) << WINDOW_BITS;

    // A distance is a legal back-reference only without borrow, non-zero
    // (no self-reference) and no further back than the window size.
    function automatic logic window_check(input logic [31:0] diff, input logic no_borrow);
        return no_borrow && (diff != 32'd0) && ({1'b0, diff} <= WINDOW_MAX);
    endfunction

    // Control
    logic vld_p1;
    logic s2_load;
    logic in_fire;

    assign s2_load  = vld_p1 && (!out_valid || out_ready);
    assign in_ready = !vld_p1 || s2_load;
    assign in_fire  = in_valid && in_ready;

    // ---- Stage 0 -> 1: low half, a + ~b + ~bi ----
    logic [16:0] lo_sum_p0;

    assign lo_sum_p0 = {1'b0, in_a[15:0]} + {1'b0, ~in_b[15:0]} + {16'd0, ~in_bi};

    logic [15:0]          d_lo_p1;
    logic                 c16_p1;
    logic [15:0]          a_hi_p1;
    logic [15:0]          b_hi_p1;
    logic [TAG_WIDTH-1:0] tag_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
        end else if (in_fire) begin
            vld_p1 <= 1'b1;
        end else if (s2_load) begin
            vld_p1 <= 1'b0;
        end
    end

    // Stage-1 data needs no reset: it is only consumed while vld_p1 is set.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            d_lo_p1 <= lo_sum_p0[15:0];
            c16_p1  <= lo_sum_p0[16];
            a_hi_p1 <= in_a[31:16];
            b_hi_p1 <= in_b[31:16];
            tag_p1  <= in_tag;
        end
    end

    // ---- Stage 1 -> 2: high half, window check, output register ----
    logic [16:0] hi_sum_p1;
    logic [31:0] diff_p1;

    assign hi_sum_p1 = {1'b0, a_hi_p1} + {1'b0, ~b_hi_p1} + {16'd0, c16_p1};
    assign diff_p1   = {hi_sum_p1[15:0], d_lo_p1};

    // The output register is fully reset so a cleared port reads all zeros.
    // It only reloads on s2_load, which keeps a stalled result stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            out_diff      <= 32'd0;
            out_bo        <= 1'b0;
            out_in_window <= 1'b0;
            out_tag       <= '0;
        end else if (s2_load) begin
            out_valid     <= 1'b1;
            out_diff      <= diff_p1;
            out_bo        <= ~hi_sum_p1[16];
            out_in_window <= window_check(diff_p1, hi_sum_p1[16]);
            out_tag       <= tag_p1;
        end else if (out_valid && out_ready) begin
            out_valid     <= 1'b0;
        end
    end

endmodule
